// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-to-read bypass and a per-register
// pending-write scoreboard. Register 0 is hard zero; SP_IDX resets to SP_INIT.
module reg_file_mp_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdval,
  input  logic              i_pend,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);
  logic              w_nz;
  logic              w_wr_hit;
  logic [DATA_W-1:0] w_next;
  logic [DATA_W-1:0] r_data;

  assign w_nz     = (i_addr != '0);
  assign w_wr_hit = i_wr_en && (i_wr_addr == i_addr) && w_nz;
  // A same-cycle write to this address both forwards its data and retires the hazard.
  assign w_next   = w_wr_hit ? i_wr_data : (w_nz ? i_rdval : '0);
  assign o_busy   = i_pend && w_nz && !w_wr_hit;
  assign o_data   = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_data <= '0;
    else if (i_en) r_data <= w_next;
  end
endmodule

module reg_file_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 252
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  pend_set,
  input  logic [ADDR_W-1:0]     pend_addr
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic [DEPTH-1:0]             r_pend;
  logic [NRD-1:0][ADDR_W-1:0]   w_raddr;
  logic [NRD-1:0][DATA_W-1:0]   w_rdata;
  logic                         w_wr_ok;
  logic                         w_set_ok;

  assign w_raddr  = rd_addr;
  assign rd_data  = w_rdata;
  assign w_wr_ok  = wr_en && (wr_addr != '0);
  assign w_set_ok = pend_set && (pend_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        r_regs[k] <= (k == SP_IDX && k != 0) ? DATA_W'(SP_INIT) : '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Clear-on-write first, then set, so a simultaneous set to the same address wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      if (w_wr_ok)  r_pend[wr_addr]   <= 1'b0;
      if (w_set_ok) r_pend[pend_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    reg_file_mp_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (rd_en[g]),
      .i_addr    (w_raddr[g]),
      .i_rdval   (r_regs[w_raddr[g]]),
      .i_pend    (r_pend[w_raddr[g]]),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_data    (w_rdata[g]),
      .o_busy    (rd_busy[g])
    );
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter SP_IDX, default 29, index of the stack-pointer register.
REQ-005 Parameter SP_INIT, default 252, reset value of register SP_IDX.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset; all state changes on the rising clock edge.
REQ-007 clk  input  1  clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 rd_en  input  NRD  per-port read enable.
REQ-010 rd_addr  input  NRD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 rd_data  output  NRD*DATA_W  packed registered read data.
REQ-012 rd_busy  output  NRD  per-port combinational flag: the addressed register has a pending write.
REQ-013 wr_en  input  1  write enable.
REQ-014 wr_addr  input  ADDR_W  write address.
REQ-015 wr_data  input  DATA_W  write data.
REQ-016 pend_set  input  1  marks pend_addr as awaiting a future write (issued load/long op).
REQ-017 pend_addr  input  ADDR_W  register to mark pending.

Function
REQ-018 Register 0 SHALL always read 0; writes and pend_set to address 0 SHALL be ignored.
REQ-019 Write: when wr_en=1 and wr_addr!=0, regs[wr_addr] SHALL take wr_data at the rising edge.
REQ-020 Read: when rd_en[i]=1, rd_data port i SHALL load regs[rd_addr[i]] at the rising edge (1-cycle latency); when rd_en[i]=0, port i SHALL hold its value.
REQ-021 Bypass: if rd_en[i]=1, wr_en=1 and rd_addr[i]==wr_addr!=0 in the same cycle, port i SHALL capture wr_data, not the old contents.
REQ-022 All read ports SHALL operate independently; equal addresses on several ports SHALL return identical data.
REQ-023 Scoreboard: one pending bit per register; pend_set=1 with pend_addr!=0 SHALL set bit pend_addr at the edge.
REQ-024 A write (wr_en=1, wr_addr!=0) SHALL clear pending bit wr_addr at the edge.
REQ-025 Simultaneous pend_set and write to the same address: set SHALL win (bit ends 1; data still written).
REQ-026 rd_busy[i] SHALL be 1 iff pending[rd_addr[i]]=1, rd_addr[i]!=0, and NOT (wr_en=1 and wr_addr==rd_addr[i]) in the current cycle.
REQ-027 pend_set on an already pending register SHALL leave it pending (no count; single outstanding write per register).
REQ-028 Address arithmetic SHALL be unsigned ADDR_W bits; no out-of-range addresses exist.

Reset
REQ-029 rst_n=0 SHALL immediately force all registers to 0 except regs[SP_IDX]=SP_INIT, all rd_data ports to 0, all pending bits to 0.
REQ-030 While rst_n=0, writes, reads and pend_set SHALL have no effect; rd_busy SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard any same-cycle write; first post-reset edge with rst_n=1 behaves normally.

Verification
REQ-032 Reset, then rd_en=2'b11, rd_addr0=29, rd_addr1=5 -> next cycle rd_data0=252, rd_data1=0.
REQ-033 wr_en=1, wr_addr=8, wr_data=0x0000_0001; next cycle read port0 addr 8 -> rd_data0=1; write addr 0 data 0xFFFF_FFFF then read addr 0 -> 0.
REQ-034 Same cycle: wr_en=1, wr_addr=9, wr_data=0xDEAD_BEEF, rd_en0=1, rd_addr0=9 -> next cycle rd_data0=0xDEAD_BEEF.
REQ-035 pend_set, pend_addr=10; next cycle rd_addr1=10 -> rd_busy1=1; cycle with wr_en=1, wr_addr=10 -> rd_busy1=0 same cycle, stays 0 after edge.
REQ-036 pend_set and wr_en both to addr 11 same cycle -> after edge rd_busy for addr 11 =1, regs[11]=wr_data.
REQ-037 Write 0x55 to addr 12, pend_set 13, then pulse rst_n=0 between edges -> rd_data=0, regs[12] reads 0, rd_busy for 13 =0, regs[29]=252.
